am2942_seq: RTL

DMA channel sequencer that drives one am2942 programmable address/word counter. It captures a block descriptor from the host and programs the am2942 control, address and word-count registers over the shared d bus. It then runs the device request/acknowledge handshake, issuing one count instruction per transfer, and stops when the am2942 asserts DONE. The block sits between the host/microcode and the am2942, on the controlling side of its instruction interface.

---
 rtl/am2942_seq_if.sv | 35 +++
 rtl/am2942_seq.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/am2942_seq_if.sv
// Host/device-side signal bundle between the DMA sequencer and its environment:
// block descriptor, device handshake, and the am2942 instruction/bus controls.
interface am2942_seq_if;
   logic       start;
   logic       reinit;
   logic       abort;
   logic [1:0] mode;
   logic       decr;
   logic [7:0] addr;
   logic [7:0] count;
   logic       drq;
   logic       dack;
   logic       done;
   logic [3:0] i;
   logic       ien_;
   logic       aci_;
   logic       wci_;
   logic       oed_;
   logic [7:0] dout;
   logic       dout_en;
   logic       busy;
   logic       irq;

   // Host/environment side: issues commands and device requests, observes the sequencer.
   modport master (
      output start, reinit, abort, mode, decr, addr, count, drq, done,
      input  dack, i, ien_, aci_, wci_, oed_, dout, dout_en, busy, irq
   );

   // Sequencer side.
   modport slave (
      input  start, reinit, abort, mode, decr, addr, count, drq, done,
      output dack, i, ien_, aci_, wci_, oed_, dout, dout_en, busy, irq
   );
endinterface

// File: rtl/am2942_seq.sv
// DMA channel sequencer: loads an am2942 counter slice from a captured descriptor,
// then runs the drq/dack handshake with one count instruction per transfer until DONE.
module am2942_seq (
   input  logic          cp,
   input  logic          rst,
   am2942_seq_if.slave   bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_WCR, S_LAR, S_LWC, S_REIN, S_WAIT, S_XFER, S_FIN
   } state_t;

   state_t     state_reg, state_next;
   logic [1:0] mode_reg, mode_next;
   logic       decr_reg, decr_next;
   logic [7:0] addr_reg, addr_next;
   logic [7:0] count_reg, count_next;
   logic       loaded_reg;

   logic [3:0] i_reg;
   logic       ien_reg, aci_reg, wci_reg, oed_reg;
   logic [7:0] dout_reg;
   logic       dout_en_reg, dack_reg, busy_reg, irq_reg;

   always_comb begin
      state_next = state_reg;
      mode_next  = mode_reg;
      decr_next  = decr_reg;
      addr_next  = addr_reg;
      count_next = count_reg;
      case (state_reg)
         S_IDLE: begin
            if (bus.start) begin
               mode_next  = bus.mode;
               decr_next  = bus.decr;
               addr_next  = bus.addr;
               count_next = bus.count;
               state_next = (bus.reinit && loaded_reg) ? S_REIN : S_WCR;
            end
         end
         S_WCR:   state_next = S_LAR;
         S_LAR:   state_next = S_LWC;
         S_LWC:   state_next = S_WAIT;
         S_REIN:  state_next = S_WAIT;
         S_WAIT:  state_next = bus.drq ? S_XFER : S_WAIT;
         S_XFER:  state_next = bus.done ? S_FIN : S_WAIT;
         S_FIN:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      // abort still routes through FIN so the host always sees an irq.
      if (bus.abort && state_reg != S_IDLE)
         state_next = S_FIN;
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge cp or posedge rst) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         mode_reg    <= 2'b00;
         decr_reg    <= 1'b0;
         addr_reg    <= 8'h00;
         count_reg   <= 8'h00;
         loaded_reg  <= 1'b0;
         i_reg       <= 4'b0111;
         ien_reg     <= 1'b1;
         aci_reg     <= 1'b1;
         wci_reg     <= 1'b1;
         oed_reg     <= 1'b1;
         dout_reg    <= 8'h00;
         dout_en_reg <= 1'b0;
         dack_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         irq_reg     <= 1'b0;
      end else begin
         state_reg  <= state_next;
         mode_reg   <= mode_next;
         decr_reg   <= decr_next;
         addr_reg   <= addr_next;
         count_reg  <= count_next;
         if (state_next == S_LWC)
            loaded_reg <= 1'b1;

         i_reg       <= 4'b0111;
         ien_reg     <= 1'b0;
         aci_reg     <= 1'b1;
         wci_reg     <= 1'b1;
         oed_reg     <= 1'b0;
         dout_en_reg <= 1'b0;
         dack_reg    <= 1'b0;
         busy_reg    <= 1'b1;
         irq_reg     <= 1'b0;
         case (state_next)
            S_IDLE: begin
               ien_reg  <= 1'b1;
               oed_reg  <= 1'b1;
               busy_reg <= 1'b0;
            end
            S_WCR: begin
               i_reg       <= 4'b0000;
               oed_reg     <= 1'b1;
               dout_en_reg <= 1'b1;
               dout_reg    <= {5'b00000, decr_next, mode_next};
            end
            S_LAR: begin
               i_reg       <= 4'b0101;
               oed_reg     <= 1'b1;
               dout_en_reg <= 1'b1;
               dout_reg    <= addr_next;
            end
            S_LWC: begin
               i_reg       <= 4'b0110;
               oed_reg     <= 1'b1;
               dout_en_reg <= 1'b1;
               dout_reg    <= count_next;
            end
            S_REIN:  i_reg <= 4'b0100;
            S_WAIT:  i_reg <= 4'b0111;
            S_XFER: begin
               aci_reg  <= 1'b0;
               wci_reg  <= 1'b0;
               dack_reg <= 1'b1;
            end
            S_FIN: begin
               ien_reg  <= 1'b1;
               oed_reg  <= 1'b1;
               busy_reg <= 1'b0;
               irq_reg  <= 1'b1;
            end
            default: begin
               ien_reg  <= 1'b1;
               oed_reg  <= 1'b1;
               busy_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.i       = i_reg;
   assign bus.ien_    = ien_reg;
   assign bus.aci_    = aci_reg;
   assign bus.wci_    = wci_reg;
   assign bus.oed_    = oed_reg;
   assign bus.dout    = dout_reg;
   assign bus.dout_en = dout_en_reg;
   assign bus.dack    = dack_reg;
   assign bus.busy    = busy_reg;
   assign bus.irq     = irq_reg;
endmodule
